apb_completer_mem: RTL and testbench

APB completer (slave) backed by a small word-addressed register memory, with optional programmable wait states and error signalling. It answers the select/enable/write/address/data transfers issued by the APB requester side of the bench environment and returns PRDATA, PREADY and PSLVERR. It serves as a standalone DUT target and as a reusable responder model on any of the four select lines.

---
 rtl/apb_completer_mem_pkg.sv | 34 +++
 rtl/apb_completer_mem_if.sv | 31 +++
 rtl/apb_completer_mem_wait_ctr.sv | 41 ++++
 rtl/apb_completer_mem.sv | 202 ++++++++++++++++++++
 tb/tb_apb_completer_mem.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_completer_mem_pkg.sv
// ---------------------------------------------------------------------------
// apb_completer_pkg
// Shared definitions for the APB completer memory:
//   state_e   - FSM state encoding (IDLE, WAIT, READY)
//   CNT_W     - width of the wait-state down-counter
//   idx_width - word-index width for a given memory depth
//   addr_err  - misaligned / out-of-range byte address predicate
// Optional feature macro used by the importing files: APB_COMPLETER_WAIT_EN
// ---------------------------------------------------------------------------
package apb_completer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Holds WAIT_CYCLES in the range 0..15.
  localparam int CNT_W = 4;

  // Number of index bits needed to address 'depth' words (at least 1).
  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // A byte address is rejected when it is not word aligned or when it
  // falls beyond the last word of a 'depth'-word memory.
  function automatic logic addr_err(input logic [63:0] addr, input int depth);
    logic [63:0] limit;
    limit = 64'(depth) << 2;
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/apb_completer_mem_if.sv
// ---------------------------------------------------------------------------
// apb_completer_mem_if
// APB bus bundle between a requester and the completer memory.
//   psel, penable, pwrite, paddr, pwdata : requester -> completer
//   prdata, pready, pslverr              : completer -> requester
// Modports: master (requester side), slave (completer side).
// ---------------------------------------------------------------------------
interface apb_completer_mem_if #(
  parameter int WIDTH = 32
);

  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [WIDTH-1:0] paddr;
  logic [WIDTH-1:0] pwdata;
  logic [WIDTH-1:0] prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_completer_mem_wait_ctr.sv
// ---------------------------------------------------------------------------
// apb_wait_ctr
// Loadable down-counter used to time APB wait states.
// Ports:
//   clk      in  clock, all updates on rising edge
//   rst      in  asynchronous active-high reset (count -> 0)
//   load     in  load load_val (has priority over dec)
//   load_val in  CNT_W value to load
//   dec      in  decrement enable; the counter saturates at 0
//   cnt      out current count
//   is_one   out high while the count equals 1
// Built only when APB_COMPLETER_WAIT_EN is defined.
// ---------------------------------------------------------------------------
module apb_wait_ctr
  import apb_completer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign cnt    = cnt_reg;
  assign is_one = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/apb_completer_mem.sv
// ---------------------------------------------------------------------------
// apb_completer_mem
// APB completer backed by a DEPTH x WIDTH word memory, with optional
// programmable wait states and error response for bad addresses.
// Parameters:
//   WIDTH       address / data width
//   DEPTH       number of words (power of two, >= 2)
//   WAIT_CYCLES wait states per transfer (0..15), used only when the
//               APB_COMPLETER_WAIT_EN macro is defined
// Ports:
//   pclk    in  clock
//   preset  in  asynchronous active-high reset
//   bus     apb_completer_mem_if.slave (psel/penable/pwrite/paddr/pwdata
//           in, prdata/pready/pslverr out, all outputs registered)
// Optional feature macro: APB_COMPLETER_WAIT_EN (wait counter + WAIT state).
// ---------------------------------------------------------------------------
module apb_completer_mem
  import apb_completer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                pclk,
  input  logic                preset,
  apb_completer_mem_if.slave  bus
);

  localparam int IDX_W = idx_width(DEPTH);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] WAIT  = ST_WAIT;
  localparam logic [1:0] READY = ST_READY;

  localparam logic [CNT_W-1:0] WAIT_LD = WAIT_CYCLES[CNT_W-1:0];

  // FSM and latched setup-phase attributes
  logic [1:0]       state_reg, state_next;
  logic             wr_reg;
  logic             err_reg;
  logic [IDX_W-1:0] idx_reg;

  // Registered bus outputs
  logic [WIDTH-1:0] prdata_reg;
  logic             pready_reg;
  logic             pslverr_reg;

  // Memory
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] word_we;
  logic             mem_we;

  logic             setup_phase;
  logic             access_phase;
  logic [IDX_W-1:0] idx_in;
  logic             err_in;
  logic             enter_ready;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_err;
  logic             rd_wr;
  logic             wait_zero;
  logic             ctr_is_one;

  assign setup_phase  = bus.psel & ~bus.penable;
  assign access_phase = bus.psel &  bus.penable;
  assign idx_in       = bus.paddr[IDX_W+1:2];
  assign err_in       = addr_err(64'(bus.paddr), DEPTH);

`ifdef APB_COMPLETER_WAIT_EN
  logic [CNT_W-1:0] ctr_cnt;
  logic             ctr_load;
  logic             ctr_dec;

  assign ctr_load  = (state_reg == IDLE) && setup_phase;
  assign ctr_dec   = (state_reg == WAIT) && access_phase;
  assign wait_zero = (WAIT_LD == '0);

  apb_wait_ctr u_wait_ctr (
    .clk      (pclk),
    .rst      (preset),
    .load     (ctr_load),
    .load_val (WAIT_LD),
    .dec      (ctr_dec),
    .cnt      (ctr_cnt),
    .is_one   (ctr_is_one)
  );

  // The count value itself is only observed through is_one.
  logic unused_cnt;
  assign unused_cnt = ^ctr_cnt;
`else
  // Zero-wait build: every setup phase goes straight to READY.
  assign wait_zero  = 1'b1;
  assign ctr_is_one = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^WAIT_LD;
`endif

  // Next state and the "entering READY this edge" strobe.
  always_comb begin
    state_next  = state_reg;
    enter_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        if (setup_phase) begin
          if (wait_zero) begin
            state_next  = READY;
            enter_ready = 1'b1;
          end else begin
            state_next  = WAIT;
          end
        end
      end
`ifdef APB_COMPLETER_WAIT_EN
      WAIT: begin
        // Any edge that is not an access phase aborts the transfer.
        if (!access_phase) begin
          state_next = IDLE;
        end else if (ctr_is_one) begin
          state_next  = READY;
          enter_ready = 1'b1;
        end
      end
`endif
      READY: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // On a zero-wait entry the setup attributes are being latched on the
  // same edge, so take them straight from the bus; otherwise use the
  // copies captured at the setup edge.
  always_comb begin
    if (state_reg == IDLE) begin
      rd_idx = idx_in;
      rd_err = err_in;
      rd_wr  = bus.pwrite;
    end else begin
      rd_idx = idx_reg;
      rd_err = err_reg;
      rd_wr  = wr_reg;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg   <= IDLE;
      wr_reg      <= 1'b0;
      err_reg     <= 1'b0;
      idx_reg     <= '0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && setup_phase) begin
        wr_reg  <= bus.pwrite;
        err_reg <= err_in;
        idx_reg <= idx_in;
      end
      pready_reg  <= enter_ready;
      pslverr_reg <= enter_ready & rd_err;
      if (enter_ready && !rd_err && !rd_wr) begin
        prdata_reg <= mem_reg[rd_idx];
      end else begin
        prdata_reg <= '0;
      end
    end
  end

  // Write lands on the completion edge (the edge leaving READY), so the
  // data sampled is PWDATA as presented during the final access cycle.
  assign mem_we = (state_reg == READY) && wr_reg && !err_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
    assign word_we[gi] = mem_we && (idx_reg == IDX_W'(gi));
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we[i]) begin
          mem_reg[i] <= bus.pwdata;
        end
      end
    end
  end

  assign bus.prdata  = prdata_reg;
  assign bus.pready  = pready_reg;
  assign bus.pslverr = pslverr_reg;

endmodule

// File: tb/tb_apb_completer_mem.sv
// ---------------------------------------------------------------------------
// tb_apb_completer_mem
// Directed bench for apb_completer_mem (DEPTH=16, WAIT_CYCLES=3). Expected
// latency follows APB_COMPLETER_WAIT_EN: 4 access cycles when defined,
// 1 access cycle otherwise.
// ---------------------------------------------------------------------------
module tb_apb_completer_mem;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int WAITS = 3;
`ifdef APB_COMPLETER_WAIT_EN
  localparam int EXP_W = WAITS;
`else
  localparam int EXP_W = 0;
`endif
  localparam int EXP_LAT = EXP_W + 1;

  logic pclk;
  logic preset;
  int   checks;
  int   errors;

  apb_completer_mem_if #(.WIDTH(WIDTH)) bus ();

  apb_completer_mem #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAITS)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transfer. Starts driving the setup phase immediately, so
  // consecutive calls are back-to-back with no idle cycle. Returns at #1
  // after the completion edge with the bus idle. lat = access cycles up to
  // and including the PREADY cycle, or -1 on timeout.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wdata;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    lat   = -1;
    rdata = 'x;
    err   = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      if (bus.pready === 1'b1) begin
        lat   = n;
        rdata = bus.prdata;
        err   = bus.pslverr;
        break;
      end
      @(posedge pclk); #1;
    end
    if (lat > 0) begin
      @(posedge pclk); #1;
    end
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    $display("xfer %s addr=0x%08h wdata=0x%08h rdata=0x%08h pslverr=%b lat=%0d",
             wr ? "WR" : "RD", addr, wdata, rdata, err, lat);
  endtask

  task automatic idle_cycle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lt;

    checks = 0;
    errors = 0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    preset      = 1'b1;

    // Reset state
    #1;
    check("rst_pready", 32'(bus.pready), 32'd0);
    check("rst_pslverr", 32'(bus.pslverr), 32'd0);
    check("rst_prdata", bus.prdata, 32'h0);
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk); #1;

    // Basic write then read
    xfer(1'b1, 32'h4, 32'hDEADBEEF, rd, er, lt);
    check("wr4_lat", 32'(lt), 32'(EXP_LAT));
    check("wr4_err", 32'(er), 32'd0);
    check("wr4_prdata", rd, 32'h0);
    check("wr4_idle_pready", 32'(bus.pready), 32'd0);
    idle_cycle();
    xfer(1'b0, 32'h4, 32'h0, rd, er, lt);
    check("rd4_lat", 32'(lt), 32'(EXP_LAT));
    check("rd4_err", 32'(er), 32'd0);
    check("rd4_data", rd, 32'hDEADBEEF);
    check("rd4_idle_prdata", bus.prdata, 32'h0);
    idle_cycle();

    // Back-to-back write then read of word 0
    xfer(1'b1, 32'h0, 32'h00000011, rd, er, lt);
    check("b2b_wr_lat", 32'(lt), 32'(EXP_LAT));
    xfer(1'b0, 32'h0, 32'h0, rd, er, lt);
    check("b2b_rd_lat", 32'(lt), 32'(EXP_LAT));
    check("b2b_rd_data", rd, 32'h00000011);
    idle_cycle();

    // Last word boundary
    xfer(1'b1, 32'h3C, 32'h5A5A0001, rd, er, lt);
    check("wr3c_err", 32'(er), 32'd0);
    xfer(1'b0, 32'h3C, 32'h0, rd, er, lt);
    check("rd3c_data", rd, 32'h5A5A0001);
    idle_cycle();

    // Error transfers: out of range write (would alias word 0) and misaligned read
    xfer(1'b1, 32'h40, 32'hFFFFFFFF, rd, er, lt);
    check("err40_lat", 32'(lt), 32'(EXP_LAT));
    check("err40_pslverr", 32'(er), 32'd1);
    check("err40_prdata", rd, 32'h0);
    idle_cycle();
    xfer(1'b0, 32'h6, 32'h0, rd, er, lt);
    check("err6_lat", 32'(lt), 32'(EXP_LAT));
    check("err6_pslverr", 32'(er), 32'd1);
    check("err6_prdata", rd, 32'h0);
    check("err6_idle_pslverr", 32'(bus.pslverr), 32'd0);
    idle_cycle();
    xfer(1'b0, 32'h0, 32'h0, rd, er, lt);
    check("err_mem0_unchanged", rd, 32'h00000011);
    check("err_mem0_pslverr", 32'(er), 32'd0);
    xfer(1'b0, 32'h4, 32'h0, rd, er, lt);
    check("err_mem4_unchanged", rd, 32'hDEADBEEF);
    idle_cycle();

`ifdef APB_COMPLETER_WAIT_EN
    // Abort: drop PSEL during WAIT of a write to 0xC
    xfer(1'b1, 32'hC, 32'hCAFEF00D, rd, er, lt);
    idle_cycle();
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 32'hC;
    bus.pwdata  = 32'h12345678;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(posedge pclk); #1;
    check("abort_wait_pready", 32'(bus.pready), 32'd0);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(posedge pclk); #1;
    check("abort_state_idle", 32'(dut.state_reg), 32'd0);
    check("abort_pready0", 32'(bus.pready), 32'd0);
    @(posedge pclk); #1;
    check("abort_pready1", 32'(bus.pready), 32'd0);
    $display("abort WR addr=0x0000000c wdata=0x12345678");
    xfer(1'b0, 32'hC, 32'h0, rd, er, lt);
    check("abort_rdc_lat", 32'(lt), 32'(EXP_LAT));
    check("abort_rdc_data", rd, 32'hCAFEF00D);
    idle_cycle();
`endif

    // Reset in the middle of a write to 0x8 whose word already holds data
    xfer(1'b1, 32'h8, 32'hA5A5A5A5, rd, er, lt);
    xfer(1'b0, 32'h8, 32'h0, rd, er, lt);
    check("pre_rst_rd8", rd, 32'hA5A5A5A5);
    idle_cycle();
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 32'h8;
    bus.pwdata  = 32'h00000012;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    #2;
    preset = 1'b1;
    #1;
    check("midrst_pready", 32'(bus.pready), 32'd0);
    check("midrst_pslverr", 32'(bus.pslverr), 32'd0);
    check("midrst_prdata", bus.prdata, 32'h0);
    check("midrst_state", 32'(dut.state_reg), 32'd0);
    $display("reset asserted mid-transfer WR addr=0x00000008");
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk); #1;
    xfer(1'b0, 32'h8, 32'h0, rd, er, lt);
    check("post_rst_rd8", rd, 32'h0);
    check("post_rst_rd8_lat", 32'(lt), 32'(EXP_LAT));
    xfer(1'b0, 32'h4, 32'h0, rd, er, lt);
    check("post_rst_rd4", rd, 32'h0);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
